piece_randomizer: RTL and testbench

- Produces the random piece stream consumed by the block state manager.
- Drives rand_num1..rand_num4 using 7-bag semantics: each aligned group of 7 drawn piece types is a permutation of 0..6.
- Watches game_current_state and treats entry into INITIAL or CLEAR_ROW as a consumption event, then refills its two-slot queue in the background from a free-running LFSR.

---
 rtl/piece_randomizer_pkg.sv | 46 ++++
 rtl/lfsr16.sv | 39 +++
 rtl/piece_randomizer.sv | 162 ++++++++++++++++
 tb/tb_piece_randomizer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_randomizer_pkg.sv
// Shared definitions for the piece randomizer.
//   - Game FSM state encodings driven on game_current_state by the game controller.
//   - Piece-type encodings and PIECE_COUNT.
//   - Refill FSM state type and a lowest-unused-type helper for the bag mask.
package piece_randomizer_pkg;

    // Game FSM state encodings (3-bit game_current_state bus)
    localparam logic [2:0] INITIAL      = 3'd0;
    localparam logic [2:0] GEN_PIECE    = 3'd1;
    localparam logic [2:0] FALLING      = 3'd2;
    localparam logic [2:0] ROTATE_PIECE = 3'd3;
    localparam logic [2:0] CLEAR_ROW    = 3'd4;
    localparam logic [2:0] GAME_OVER    = 3'd5;
    localparam logic [2:0] PAUSED       = 3'd6;
    localparam logic [2:0] LOCK_PIECE   = 3'd7;

    localparam int PIECE_COUNT = 7;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_type_t;

    typedef enum logic {
        RF_IDLE = 1'b0,
        RF_DRAW = 1'b1
    } refill_state_t;

    // Lowest piece type whose bit is clear in the bag mask. The mask is never
    // all ones when this is consulted, because a full bag is cleared the same
    // cycle it fills.
    function automatic logic [2:0] lowest_unused(input logic [6:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = PIECE_COUNT - 1; i >= 0; i--) begin
            if (!mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every cycle.
// Ports:
//   clk, rst      - clock and synchronous active-high reset (loads SEED)
//   seed_load     - one-cycle strobe: next state becomes seed_in
//   seed_in       - replacement seed; zero is mapped to 16'h0001
//   lfsr_state    - full current register contents
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [15:0] lfsr_state
);

    // An all-zero register would lock up forever, so zero seeds become 1.
    localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = {lfsr_q[14:0], feedback};
        if (seed_load) begin
            lfsr_d = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= RESET_VAL;
        else     lfsr_q <= lfsr_d;
    end

    assign lfsr_state = lfsr_q;

endmodule

// File: rtl/piece_randomizer.sv
// 7-bag random piece source with a two-slot queue (head H, tail T).
// A take fires on entry into INITIAL (flush both slots) or CLEAR_ROW (pop H,
// T moves up). A background refill FSM draws candidates from the LFSR,
// rejecting 7 and types already used in the current bag, with a deterministic
// fallback after MAX_TRIES rejections.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   game_current_state   - game FSM state (encodings in piece_randomizer_pkg)
//   seed_load, seed_in   - reseed strobe and value for the LFSR
//   rand_num1/rand_num3  - tail type / rotation (stale while rand_valid=0)
//   rand_num2/rand_num4  - head type / rotation
//   rand_valid           - both slots full
//   underflow            - sticky: a take happened while not valid
module piece_randomizer
    import piece_randomizer_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  game_current_state,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [2:0]  rand_num1,
    output logic [2:0]  rand_num2,
    output logic [1:0]  rand_num3,
    output logic [1:0]  rand_num4,
    output logic        rand_valid,
    output logic        underflow
);

    localparam int RETRY_W = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

    logic [15:0]        lfsr;

    logic [2:0]         t_q, t_d;
    logic [2:0]         h_q, h_d;
    logic [1:0]         rot_t_q, rot_t_d;
    logic [1:0]         rot_h_q, rot_h_d;
    logic [1:0]         count_q, count_d;
    logic [6:0]         used_q, used_d;
    logic [2:0]         state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               underflow_q, underflow_d;
    refill_state_t      fsm_q, fsm_d;

    logic               take_init;
    logic               take_clear;
    logic [1:0]         count_post;
    logic [2:0]         cand;
    logic               cand_ok;
    logic [7:0]         used_ext;
    logic [2:0]         pick;
    logic [6:0]         mask_next;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .lfsr_state(lfsr)
    );

    always_comb begin
        t_d         = t_q;
        h_d         = h_q;
        rot_t_d     = rot_t_q;
        rot_h_d     = rot_h_q;
        used_d      = used_q;
        retry_d     = retry_q;
        underflow_d = underflow_q;
        state_d     = game_current_state;
        pick        = 3'd0;
        mask_next   = used_q;

        take_init  = (game_current_state == INITIAL)   && (state_q != INITIAL);
        take_clear = (game_current_state == CLEAR_ROW) && (state_q != CLEAR_ROW);

        // Take is applied first; the draw below sees the post-take occupancy.
        count_post = count_q;
        if (take_init) begin
            count_post = 2'd0;
            if (count_q != 2'd2) underflow_d = 1'b1;
        end else if (take_clear) begin
            if (count_q == 2'd2) begin
                h_d        = t_q;
                rot_h_d    = rot_t_q;
                count_post = 2'd1;
            end else begin
                count_post  = 2'd0;
                underflow_d = 1'b1;
            end
        end

        // Bit 7 of the extended mask is always set so candidate 7 is rejected
        // by the same lookup as an already-used type.
        cand     = lfsr[2:0];
        used_ext = {1'b1, used_q};
        cand_ok  = !used_ext[cand];

        count_d = count_post;
        if ((fsm_q == RF_DRAW) && (count_post != 2'd2)) begin
            if (cand_ok || (retry_q == RETRY_W'(MAX_TRIES))) begin
                pick = cand_ok ? cand : lowest_unused(used_q);
                if (count_post == 2'd0) begin
                    h_d     = pick;
                    rot_h_d = lfsr[9:8];
                end else begin
                    t_d     = pick;
                    rot_t_d = lfsr[9:8];
                end
                count_d   = count_post + 2'd1;
                retry_d   = '0;
                mask_next = used_q | (7'b1 << pick);
                // A completed bag starts over immediately.
                used_d    = (mask_next == 7'h7F) ? 7'h00 : mask_next;
            end else begin
                retry_d = retry_q + 1'b1;
            end
        end

        fsm_d = (count_d == 2'd2) ? RF_IDLE : RF_DRAW;
    end

    // The reset pair (0 in T, 1 in H) is pre-marked as drawn in the first bag.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q         <= 3'd0;
            h_q         <= 3'd1;
            rot_t_q     <= 2'd0;
            rot_h_q     <= 2'd0;
            count_q     <= 2'd2;
            used_q      <= 7'b0000011;
            state_q     <= INITIAL;
            retry_q     <= '0;
            underflow_q <= 1'b0;
            fsm_q       <= RF_IDLE;
        end else begin
            t_q         <= t_d;
            h_q         <= h_d;
            rot_t_q     <= rot_t_d;
            rot_h_q     <= rot_h_d;
            count_q     <= count_d;
            used_q      <= used_d;
            state_q     <= state_d;
            retry_q     <= retry_d;
            underflow_q <= underflow_d;
            fsm_q       <= fsm_d;
        end
    end

    assign rand_num1  = t_q;
    assign rand_num2  = h_q;
    assign rand_num3  = rot_t_q;
    assign rand_num4  = rot_h_q;
    assign rand_valid = (count_q == 2'd2);
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_piece_randomizer.sv
// Scoreboard bench for piece_randomizer. A reference model (slot queue, bag
// set, LFSR arithmetic) is stepped as stimulus is issued and pushes the
// expected post-edge view; a monitor pops and compares after each edge.
module tb_piece_randomizer;
    import piece_randomizer_pkg::*;

    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          MAX_TRIES = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  game_current_state = INITIAL;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic [2:0]  rand_num1, rand_num2;
    logic [1:0]  rand_num3, rand_num4;
    logic        rand_valid, underflow;

    piece_randomizer #(.SEED(SEED), .MAX_TRIES(MAX_TRIES)) dut (
        .clk               (clk),
        .rst               (rst),
        .game_current_state(game_current_state),
        .seed_load         (seed_load),
        .seed_in           (seed_in),
        .rand_num1         (rand_num1),
        .rand_num2         (rand_num2),
        .rand_num3         (rand_num3),
        .rand_num4         (rand_num4),
        .rand_valid        (rand_valid),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int typ; int rot; } piece_t;
    typedef struct {
        int          sz;
        bit          uf;
        int          h, rh, t, rt;
        logic [15:0] lfsr;
    } exp_t;

    piece_t      slots[$];   // slots[0] is the head
    bit          seen[7];
    int          m_retry;
    bit          m_uf;
    bit          m_draw;
    logic [2:0]  m_prev;
    logic [15:0] m_lfsr;
    exp_t        exp_q[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        int v, fb;
        v  = int'(l);
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'((v * 2 + fb) % 65536);
    endfunction

    task automatic model_step(input bit r, input logic [2:0] gs, input bit sl, input logic [15:0] si);
        bit ti, tc, full;
        int c;
        piece_t p;
        if (r) begin
            slots.delete();
            p.typ = 1; p.rot = 0; slots.push_back(p);
            p.typ = 0; p.rot = 0; slots.push_back(p);
            foreach (seen[i]) seen[i] = (i < 2);
            m_retry = 0; m_uf = 0; m_draw = 0; m_prev = INITIAL; m_lfsr = SEED;
            return;
        end
        ti = (gs == INITIAL) && (m_prev != INITIAL);
        tc = (gs == CLEAR_ROW) && (m_prev != CLEAR_ROW);
        if ((ti || tc) && slots.size() < 2) m_uf = 1;
        if (ti) slots.delete();
        else if (tc && slots.size() > 0) void'(slots.pop_front());
        if (m_draw && slots.size() < 2) begin
            c = int'(m_lfsr) % 8;
            if (c == 7 || seen[c]) begin
                if (m_retry == MAX_TRIES) begin
                    c = -1;
                    for (int k = 6; k >= 0; k--) if (!seen[k]) c = k;
                end else begin
                    c = -1;
                    m_retry++;
                end
            end
            if (c >= 0) begin
                p.typ = c; p.rot = (int'(m_lfsr) / 256) % 4;
                slots.push_back(p);
                seen[c] = 1; m_retry = 0;
                full = 1;
                foreach (seen[i]) if (!seen[i]) full = 0;
                if (full) foreach (seen[i]) seen[i] = 0;
            end
        end
        m_draw = (slots.size() < 2);
        m_prev = gs;
        m_lfsr = sl ? ((si == 16'h0) ? 16'h0001 : si) : lfsr_next(m_lfsr);
    endtask

    // ---------------- driver ----------------
    logic        obs_valid, obs_uf;
    logic [2:0]  obs_num1, obs_num2;
    logic [15:0] obs_lfsr;
    bit          done = 0;

    task automatic cyc(input bit r, input logic [2:0] gs, input bit sl = 0, input logic [15:0] si = 0);
        exp_t e;
        @(negedge clk);
        obs_valid = rand_valid; obs_uf = underflow;
        obs_num1 = rand_num1; obs_num2 = rand_num2;
        obs_lfsr = dut.u_lfsr.lfsr_q;
        rst = r; game_current_state = gs; seed_load = sl; seed_in = si;
        model_step(r, gs, sl, si);
        e.sz = slots.size(); e.uf = m_uf; e.lfsr = m_lfsr;
        e.h = (e.sz > 0) ? slots[0].typ : 0; e.rh = (e.sz > 0) ? slots[0].rot : 0;
        e.t = (e.sz > 1) ? slots[1].typ : 0; e.rt = (e.sz > 1) ? slots[1].rot : 0;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rand_valid", rand_valid, (e.sz == 2));
                chk("underflow", underflow, e.uf);
                chk("lfsr_state", dut.u_lfsr.lfsr_q, e.lfsr);
                if (e.sz >= 1) begin
                    chk("head_type", rand_num2, e.h);
                    chk("head_rot", rand_num4, e.rh);
                end
                if (e.sz == 2) begin
                    chk("tail_type", rand_num1, e.t);
                    chk("tail_rot", rand_num3, e.rt);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int consumed[$];
        bit got;
        logic [6:0] mask;

        // Reset, hold INITIAL
        repeat (2) cyc(1, INITIAL);
        repeat (20) cyc(0, INITIAL);
        cyc(0, INITIAL);
        chk("reset_valid", obs_valid, 1);
        chk("reset_head", obs_num2, 1);
        chk("reset_tail", obs_num1, 0);

        // Single CLEAR_ROW take
        cyc(0, FALLING);
        cyc(0, CLEAR_ROW);
        chk("entry_head_stable", obs_num2, 1);
        got = 0;
        for (int k = 0; k < 18 && !got; k++) begin
            cyc(0, CLEAR_ROW);
            if (k == 0) chk("after_take_head", obs_num2, 0);
            if (obs_valid) got = 1;
        end
        chk("refill_within_17", got, 1);
        chk("tail_in_2_6", (obs_num1 >= 3'd2 && obs_num1 <= 3'd6), 1);
        repeat (5) cyc(0, CLEAR_ROW);

        // Underflow: CLEAR_ROW, other, CLEAR_ROW back to back
        cyc(0, FALLING);
        cyc(0, CLEAR_ROW);
        cyc(0, FALLING);
        cyc(0, CLEAR_ROW);
        repeat (20) cyc(0, GEN_PIECE);
        cyc(0, INITIAL);
        repeat (20) cyc(0, FALLING);
        chk("underflow_sticky", obs_uf, 1);

        // INITIAL retake while valid
        repeat (2) cyc(1, INITIAL);
        repeat (3) cyc(0, FALLING);
        repeat (40) cyc(0, INITIAL);
        cyc(0, INITIAL);
        chk("retake_no_underflow", obs_uf, 0);
        chk("retake_refilled", obs_valid, 1);

        // Zero seed maps to 1 and keeps moving
        cyc(0, FALLING, 1, 16'h0000);
        cyc(0, FALLING);
        chk("seed0_loaded", obs_lfsr, 16'h0001);
        cyc(0, FALLING);
        chk("seed0_advances", obs_lfsr, 16'h0002);

        // Reset asserted while drawing
        cyc(0, CLEAR_ROW);
        cyc(0, CLEAR_ROW);
        cyc(1, INITIAL);
        cyc(0, INITIAL);
        chk("rst_mid_draw_valid", obs_valid, 1);
        chk("rst_mid_draw_head", obs_num2, 1);
        chk("rst_mid_draw_tail", obs_num1, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [2:0] gs;
            int hold;
            gs = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 12);
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 49) == 0)
                    cyc(0, gs, 1, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
                else
                    cyc(0, gs);
            end
        end

        // Bag property from a fresh reset with a known seed
        repeat (2) cyc(1, INITIAL);
        cyc(0, FALLING, 1, 16'hACE1);
        for (int n = 0; n < 28; n++) begin
            cyc(0, CLEAR_ROW);
            chk("bag_take_valid", obs_valid, 1);
            consumed.push_back(int'(obs_num2));
            repeat (39) cyc(0, FALLING);
        end
        for (int g = 0; g < 4; g++) begin
            mask = 7'h00;
            for (int k = 0; k < 7; k++) mask[consumed[g*7+k]] = 1'b1;
            chk("bag_permutation", mask, 7'h7F);
        end

        repeat (2) cyc(0, FALLING);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule
